// File: rtl/key_debounce.sv
// Two-flop synchroniser plus press/release filter FSM for one active-low push-button.
// key_flag pulses one cycle and key_state flips CNT_MAX+2 edges after sync1 sees a stable new level.
module key_debounce #(
  parameter int CNT_MAX = 1_000_000,
  parameter int CNT_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILTER_DN = 2'd1,
    DOWN      = 2'd2,
    FILTER_UP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             sync2;
  logic             key_d;
  logic             nedge;
  logic             pedge;
  logic             cnt_done;

  // Reset to the idle (released) level so a key held low through reset still yields a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      key_d <= 1'b1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      key_d <= sync2;
    end
  end

  assign nedge    = key_d & ~sync2;
  assign pedge    = ~key_d & sync2;
  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      key_flag  <= 1'b0;
      key_state <= 1'b1;
    end else begin
      key_flag <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (nedge) begin
            state <= FILTER_DN;
          end
        end
        FILTER_DN: begin
          // An edge back to released wins even on the final count.
          if (pedge) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_done) begin
            state     <= DOWN;
            cnt       <= '0;
            key_flag  <= 1'b1;
            key_state <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DOWN: begin
          cnt <= '0;
          if (pedge) begin
            state <= FILTER_UP;
          end
        end
        FILTER_UP: begin
          if (nedge) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt_done) begin
            state     <= IDLE;
            cnt       <= '0;
            key_flag  <= 1'b1;
            key_state <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with CNT_MAX=10: stimulus queues expected flag cycle/level,
// a negedge monitor pops and compares on every key_flag pulse.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic key_flag;
  logic key_state;

  key_debounce #(
    .CNT_MAX(10),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_state(key_state)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int   at;
    logic st;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   errors  = 0;
  int   checks  = 0;
  int   presses = 0;
  int   p0;
  logic prev_flag = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change 2 ns after a rising edge, so the next edge is E0 and the flag lands 13 edges on.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_flag(input logic st);
    exp_t e;
    e.at = cyc + 13;
    e.st = st;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (key_flag === 1'b1) begin
      check("flag_not_back_to_back", int'(prev_flag), 0);
      if (key_state === 1'b0) presses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flag: got key_flag=1 at cycle %0d, required 0", cyc);
      end else begin
        got = sb.pop_front();
        check("flag_cycle", cyc, got.at);
        check("flag_state", int'(key_state), int'(got.st));
      end
    end
    prev_flag = (key_flag === 1'b1);
  end

  initial begin
    rst_n  = 1'b0;
    key_in = 1'b1;
    step(250);
    check("reset_flag", int'(key_flag), 0);
    check("reset_state", int'(key_state), 1);
    rst_n = 1'b1;
    step(5);

    // Clean press and release
    key_in = 1'b0;
    expect_flag(1'b0);
    step(250);
    check("held_state", int'(key_state), 0);
    key_in = 1'b1;
    expect_flag(1'b1);
    step(250);

    // Bouncy press: eight 3-cycle transitions, then a stable low
    for (int i = 0; i < 8; i++) begin
      key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(3);
    end
    key_in = 1'b0;
    expect_flag(1'b0);
    step(250);
    check("bouncy_state", int'(key_state), 0);
    key_in = 1'b1;
    expect_flag(1'b1);
    step(250);

    // Short pulses: 9 cycles, then 10 (edge back seen on the last filter count)
    key_in = 1'b0;
    step(9);
    key_in = 1'b1;
    step(30);
    key_in = 1'b0;
    step(10);
    key_in = 1'b1;
    step(30);
    check("short_pulse_state", int'(key_state), 1);

    // 11-cycle low is the shortest that confirms a press
    key_in = 1'b0;
    expect_flag(1'b0);
    step(11);
    key_in = 1'b1;
    expect_flag(1'b1);
    step(40);

    // One-cycle glitches, then a glitch that never meets a sampling edge
    repeat (3) begin
      key_in = 1'b0;
      step(1);
      key_in = 1'b1;
      step(20);
    end
    key_in = 1'b0;
    #6;
    key_in = 1'b1;
    step(30);
    check("glitch_state", int'(key_state), 1);

    // Reset while the filter counter sits at 5
    key_in = 1'b0;
    step(8);
    rst_n = 1'b0;
    step(1);
    check("midreset_flag", int'(key_flag), 0);
    check("midreset_state", int'(key_state), 1);
    step(4);
    rst_n = 1'b1;
    expect_flag(1'b0);
    step(250);
    key_in = 1'b1;
    expect_flag(1'b1);
    step(250);

    // Three press/release cycles feed a downstream up-counter
    p0 = presses;
    repeat (3) begin
      key_in = 1'b0;
      expect_flag(1'b0);
      step(250);
      key_in = 1'b1;
      expect_flag(1'b1);
      step(250);
    end
    check("counter_delta", presses - p0, 3);
    check("total_presses", presses, 7);
    check("final_state", int'(key_state), 1);

    while (sb.size() > 0) begin
      got = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_flag: got no pulse, required one at cycle %0d", got.at);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
